gerador_jogadas: RTL

Upstream move generator for the 3-deep move memory. Produces pseudo-random board squares (column and line, 3 bits each) from a free-running LFSR. On request it emits either an initial set of three mutually distinct squares, or one new square that differs from all three squares currently held in memory. Each result is delivered with a one-cycle strobe: novaJogadaInit for the set of three, novaJogada for a single square.

---
 rtl/gerador_jogadas.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/gerador_jogadas.sv
// gerador_jogadas: pseudo-random move generator feeding the 3-deep move memory.
// A free-running 16-bit Fibonacci LFSR supplies candidate squares; an FSM
// either builds a set of three distinct squares or one square that is absent
// from the memory contents, falling back to a linear scan after MAX_TRIES
// rejections so the operation always finishes in bounded time.
// Optional build macro: SEED_LOAD_EN (adds seedLoad/seedValue runtime reseed).
`timescale 1ns/1ps
module gerador_jogadas #(
    parameter int          LFSR_WIDTH = 16,
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          MAX_TRIES  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
`ifdef SEED_LOAD_EN
    input  logic                  seedLoad,
    input  logic [LFSR_WIDTH-1:0] seedValue,
`endif
    input  logic                  pedeInit,
    input  logic                  pedeJogada,
    input  logic [2:0]            memColuna1,
    input  logic [2:0]            memLinha1,
    input  logic [2:0]            memColuna2,
    input  logic [2:0]            memLinha2,
    input  logic [2:0]            memColuna3,
    input  logic [2:0]            memLinha3,
    output logic [2:0]            colunaGerada1,
    output logic [2:0]            linhaGerada1,
    output logic [2:0]            colunaGerada2,
    output logic [2:0]            linhaGerada2,
    output logic [2:0]            colunaGerada3,
    output logic [2:0]            linhaGerada3,
    output logic [2:0]            colunaGerada,
    output logic [2:0]            linhaGerada,
    output logic                  novaJogadaInit,
    output logic                  novaJogada,
    output logic                  ocupado
);

    // A zero seed would lock the LFSR, so it is promoted to 1.
    localparam logic [LFSR_WIDTH-1:0] SEED_EFF =
        (SEED == 16'h0000) ? LFSR_WIDTH'(1) : LFSR_WIDTH'(SEED);
    localparam logic [7:0] MAX_T = 8'(MAX_TRIES);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INIT1     = 3'd1,
        INIT2     = 3'd2,
        INIT3     = 3'd3,
        EMIT_INIT = 3'd4,
        ONE       = 3'd5,
        SCAN      = 3'd6,
        EMIT_ONE  = 3'd7
    } estado_t;

    estado_t               estado_q, estado_d;
    estado_t               ret_q, ret_d;      // state that handed control to SCAN
    logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
    logic [7:0]            try_q, try_d;
    logic [5:0]            scan_q, scan_d;    // last square examined by SCAN
    // Squares are kept packed as {line, column}.
    logic [5:0]            slot1_q, slot1_d;
    logic [5:0]            slot2_q, slot2_d;
    logic [5:0]            slot3_q, slot3_d;
    logic [5:0]            single_q, single_d;

    estado_t               ctx;
    logic [5:0]            cand;
    logic                  rejeita;
    logic [7:0]            try_inc;
    logic [5:0]            mem1, mem2, mem3;

    // True when the candidate collides with the exclusion set of the context.
    function automatic logic excluido(input estado_t    c,
                                      input logic [5:0] sq,
                                      input logic [5:0] s1,
                                      input logic [5:0] s2,
                                      input logic [5:0] m1,
                                      input logic [5:0] m2,
                                      input logic [5:0] m3);
        logic hit;
        hit = 1'b0;
        case (c)
            INIT2:   hit = (sq == s1);
            INIT3:   hit = (sq == s1) || (sq == s2);
            ONE:     hit = (sq == m1) || (sq == m2) || (sq == m3);
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    assign mem1 = {memLinha1, memColuna1};
    assign mem2 = {memLinha2, memColuna2};
    assign mem3 = {memLinha3, memColuna3};

    // Candidate source and rejection test for the current cycle.
    always_comb begin
        ctx     = (estado_q == SCAN) ? ret_q : estado_q;
        cand    = (estado_q == SCAN) ? (scan_q + 6'd1) : lfsr_q[5:0];
        rejeita = excluido(ctx, cand, slot1_q, slot2_q, mem1, mem2, mem3);
        try_inc = try_q + 8'd1;
    end

    // LFSR advances every cycle; an optional load overrides the shift.
    always_comb begin
        lfsr_d = {lfsr_q[LFSR_WIDTH-2:0],
                  lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
`ifdef SEED_LOAD_EN
        if (seedLoad) begin
            lfsr_d = (seedValue == '0) ? LFSR_WIDTH'(1) : seedValue;
        end
`endif
    end

    // Next-state, slot capture and try-counter logic.
    always_comb begin
        estado_d = estado_q;
        ret_d    = ret_q;
        try_d    = try_q;
        scan_d   = scan_q;
        slot1_d  = slot1_q;
        slot2_d  = slot2_q;
        slot3_d  = slot3_q;
        single_d = single_q;
        case (estado_q)
            IDLE: begin
                if (pedeInit) begin
                    estado_d = INIT1;
                    try_d    = '0;
                end else if (pedeJogada) begin
                    estado_d = ONE;
                    try_d    = '0;
                end
            end
            INIT1: begin
                slot1_d  = cand;
                try_d    = '0;
                estado_d = INIT2;
            end
            INIT2, INIT3, ONE, SCAN: begin
                if (!rejeita) begin
                    try_d = '0;
                    case (ctx)
                        INIT2: begin
                            slot2_d  = cand;
                            estado_d = INIT3;
                        end
                        INIT3: begin
                            slot3_d  = cand;
                            estado_d = EMIT_INIT;
                        end
                        default: begin
                            single_d = cand;
                            estado_d = EMIT_ONE;
                        end
                    endcase
                end else if (estado_q == SCAN) begin
                    // At most three exclusions, so this walk is short.
                    scan_d = cand;
                end else begin
                    try_d = try_inc;
                    if (try_inc >= MAX_T) begin
                        estado_d = SCAN;
                        ret_d    = estado_q;
                        scan_d   = cand;
                    end
                end
            end
            EMIT_INIT: estado_d = IDLE;
            EMIT_ONE:  estado_d = IDLE;
            default:   estado_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation silently.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= IDLE;
            ret_q    <= IDLE;
            lfsr_q   <= SEED_EFF;
            try_q    <= '0;
            scan_q   <= '0;
            slot1_q  <= '0;
            slot2_q  <= '0;
            slot3_q  <= '0;
            single_q <= '0;
        end else begin
            estado_q <= estado_d;
            ret_q    <= ret_d;
            lfsr_q   <= lfsr_d;
            try_q    <= try_d;
            scan_q   <= scan_d;
            slot1_q  <= slot1_d;
            slot2_q  <= slot2_d;
            slot3_q  <= slot3_d;
            single_q <= single_d;
        end
    end

    assign colunaGerada1  = slot1_q[2:0];
    assign linhaGerada1   = slot1_q[5:3];
    assign colunaGerada2  = slot2_q[2:0];
    assign linhaGerada2   = slot2_q[5:3];
    assign colunaGerada3  = slot3_q[2:0];
    assign linhaGerada3   = slot3_q[5:3];
    assign colunaGerada   = single_q[2:0];
    assign linhaGerada    = single_q[5:3];
    // Strobes decode straight from registered state, so they cannot overlap.
    assign novaJogadaInit = (estado_q == EMIT_INIT);
    assign novaJogada     = (estado_q == EMIT_ONE);
    assign ocupado        = (estado_q != IDLE);

endmodule
